// File: rtl/twos_serial.sv
// Bit-serial two's-complement unit: pass, negate, abs and negative-abs.
// Processes CHUNK bits per cycle through an invert-and-add-carry datapath.
module twos_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("twos_serial: WIDTH must be in 2..64");
        end
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("twos_serial: CHUNK must divide WIDTH");
        end
    endgenerate

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             sign_q, sign_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             inv_sel;
    logic [CHUNK:0]   sum;

    // Negation is invert-plus-one; the +1 enters as the initial carry.
    always_comb begin
        inv_sel = 1'b0;
        unique case (in_mode)
            2'b00: inv_sel = 1'b0;
            2'b01: inv_sel = 1'b1;
            2'b10: inv_sel = in_data[WIDTH-1];
            2'b11: inv_sel = ~in_data[WIDTH-1];
            default: inv_sel = 1'b0;
        endcase
    end

    always_comb begin
        sum = {1'b0, sh_q[CHUNK-1:0] ^ {CHUNK{inv_q}}}
            + (CHUNK+1)'(carry_q);
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        sign_d    = sign_q;
        inv_d     = inv_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    sh_d    = in_data;
                    sign_d  = in_data[WIDTH-1];
                    inv_d   = inv_sel;
                    carry_d = inv_sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d = (sh_q >> CHUNK)
                     | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                carry_d = sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            sign_q  <= 1'b0;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            sign_q  <= sign_d;
            inv_q   <= inv_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the most-negative input survives inversion with its sign bit set.
    assign out_data = out_valid ? sh_q : '0;
    assign out_ovf  = out_valid & inv_q & sign_q & sh_q[WIDTH-1];

endmodule

// File: tb/tb_twos_serial.sv
// Bench for twos_serial: vector table, corner sequences and
// randomised operands over several WIDTH/CHUNK instances.
module tb_twos_serial;

    localparam int NK = 8;
    localparam int CFG_W [NK] = '{8, 8, 8, 13, 13, 32, 32, 32};
    localparam int CFG_C [NK] = '{1, 4, 2, 1, 13, 4, 8, 32};

    logic            clk;
    logic            rst;
    logic [NK-1:0]   in_valid;
    logic [NK-1:0]   in_ready;
    logic [NK-1:0]   out_valid;
    logic [NK-1:0]   out_ready;
    logic [NK-1:0]   out_ovf;
    logic [NK-1:0]   busy;
    logic [63:0]     in_data  [NK];
    logic [63:0]     out_data [NK];
    logic [1:0]      in_mode  [NK];

    int n_tot;
    int n_fail;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        localparam int W = CFG_W[g];
        localparam int C = CFG_C[g];
        logic [W-1:0] od;
        twos_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g][W-1:0]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (od),
            .out_ovf   (out_ovf[g]),
            .busy      (busy[g])
        );
        assign out_data[g] = 64'(od);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [63:0] d;
        logic [1:0]  m;
        logic [63:0] r;
        logic        ov;
        int          lat;
    } vec_t;

    function automatic logic [63:0] msk(input int k);
        int w;
        w = CFG_W[k];
        return (w == 64) ? '1 : ((64'(1) << w) - 64'(1));
    endfunction

    // Signed arithmetic on the integer value of the operand.
    function automatic void model(input int k, input logic [63:0] x,
                                  input logic [1:0] m,
                                  output logic [63:0] r, output logic ov);
        int w;
        longint lim, v, t;
        w   = CFG_W[k];
        lim = longint'(1) << (w - 1);
        x   = x & msk(k);
        v   = x[w-1] ? (longint'(x) - (lim << 1)) : longint'(x);
        case (m)
            2'b00:   t = v;
            2'b01:   t = -v;
            2'b10:   t = (v < 0) ? -v : v;
            default: t = (v < 0) ? v : -v;
        endcase
        ov = (t >= lim) || (t < -lim);
        r  = 64'(t) & msk(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the unit idle.
    task automatic op(input int k, input logic [63:0] d, input logic [1:0] m,
                      output logic [63:0] r, output logic ov, output int lat);
        int n;
        n = 0;
        in_data[k]  = d & msk(k);
        in_mode[k]  = m;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom} & msk(k);
        in_mode[k]  = 2'($urandom);
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r  = out_data[k];
        ov = out_ovf[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        vec_t        vt[$];
        logic [63:0] r, er;
        logic        ov, eov;
        int          lat, n;

        n_tot  = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < NK; k++) begin
            in_data[k] = '0;
            in_mode[k] = 2'b00;
        end

        vt.push_back('{0, 64'h05,       2'b01, 64'hFB,       1'b0, 8});
        vt.push_back('{1, 64'h80,       2'b01, 64'h80,       1'b1, 2});
        vt.push_back('{1, 64'h80,       2'b10, 64'h80,       1'b1, 2});
        vt.push_back('{2, 64'hF6,       2'b10, 64'h0A,       1'b0, 4});
        vt.push_back('{2, 64'h0A,       2'b11, 64'hF6,       1'b0, 4});
        vt.push_back('{2, 64'h00,       2'b11, 64'h00,       1'b0, 4});
        vt.push_back('{0, 64'h7F,       2'b00, 64'h7F,       1'b0, 8});
        vt.push_back('{0, 64'h80,       2'b11, 64'h80,       1'b0, 8});
        vt.push_back('{0, 64'hFF,       2'b10, 64'h01,       1'b0, 8});
        vt.push_back('{3, 64'h1000,     2'b01, 64'h1000,     1'b1, 13});
        vt.push_back('{3, 64'h1FFF,     2'b11, 64'h1FFF,     1'b0, 13});
        vt.push_back('{4, 64'h0001,     2'b01, 64'h1FFF,     1'b0, 1});
        vt.push_back('{5, 64'h80000000, 2'b00, 64'h80000000, 1'b0, 8});
        vt.push_back('{6, 64'h7FFFFFFF, 2'b01, 64'h80000001, 1'b0, 4});
        vt.push_back('{7, 64'h80000000, 2'b10, 64'h80000000, 1'b1, 1});
        vt.push_back('{7, 64'h00000000, 2'b01, 64'h00000000, 1'b0, 1});

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("rst_ovf[%0d]", k),   64'(out_ovf[k]),   64'd0);
            chk($sformatf("rst_data[%0d]", k),  out_data[k],       64'd0);
            chk($sformatf("rst_busy[%0d]", k),  64'(busy[k]),      64'd0);
            chk($sformatf("rst_ready[%0d]", k), 64'(in_ready[k]),  64'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        foreach (vt[i]) begin
            op(vt[i].k, vt[i].d, vt[i].m, r, ov, lat);
            chk($sformatf("vec%0d_data", i), r, vt[i].r);
            chk($sformatf("vec%0d_ovf", i),  64'(ov), 64'(vt[i].ov));
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(vt[i].lat));
        end

        // Backpressure in DONE
        in_data[0]  = 64'h05;
        in_mode[0]  = 2'b01;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_lat", 64'(n), 64'd8);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_data%0d", c),  out_data[0],        64'hFB);
            chk($sformatf("bp_valid%0d", c), 64'(out_valid[0]),  64'd1);
            chk($sformatf("bp_ready%0d", c), 64'(in_ready[0]),   64'd0);
            in_valid[0] = 1'b1;
            in_data[0]  = {$urandom, $urandom} & msk(0);
            in_mode[0]  = 2'($urandom);
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp_rel_valid", 64'(out_valid[0]), 64'd0);
        chk("bp_rel_ready", 64'(in_ready[0]),  64'd1);
        chk("bp_rel_busy",  64'(busy[0]),      64'd0);
        @(negedge clk);
        chk("bp_single", 64'(out_valid[0]), 64'd0);

        // Reset in the third RUN cycle
        in_data[0]  = 64'h33;
        in_mode[0]  = 2'b01;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_busy_pre", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy",  64'(busy[0]),      64'd0);
        chk("mr_valid", 64'(out_valid[0]), 64'd0);
        chk("mr_ready", 64'(in_ready[0]),  64'd1);
        op(0, 64'h01, 2'b01, r, ov, lat);
        chk("mr_data", r, 64'hFF);
        chk("mr_ovf",  64'(ov), 64'd0);
        chk("mr_lat",  64'(lat), 64'd8);

        // Randomised operands
        for (int i = 0; i < 150; i++) begin
            int          k;
            logic [63:0] d;
            logic [1:0]  m;
            k = int'($urandom_range(0, NK - 1));
            m = 2'($urandom);
            if ($urandom_range(0, 7) == 0)
                d = 64'(1) << (CFG_W[k] - 1);
            else
                d = {$urandom, $urandom} & msk(k);
            model(k, d, m, er, eov);
            op(k, d, m, r, ov, lat);
            chk($sformatf("rnd%0d_data k%0d d%0h m%0d", i, k, d, m), r, er);
            chk($sformatf("rnd%0d_ovf", i), 64'(ov), 64'(eov));
            chk($sformatf("rnd%0d_lat", i), 64'(lat),
                64'(CFG_W[k] / CFG_C[k]));
        end

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule

// File: doc/twos_serial.md
TWOS_SERIAL -- requirements
Module: twos_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal values 2..64.
REQ-002 SHALL have parameter CHUNK, default 1: bits processed per cycle; WIDTH % CHUNK == 0 is required; elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-005 SHALL have port in_valid  input  1: operand offered.
REQ-006 SHALL have port in_ready  output  1: block accepts an operand this cycle.
REQ-007 SHALL have port in_data  input  WIDTH: two's-complement operand.
REQ-008 SHALL have port in_mode  input  2: 00 pass, 01 negate, 10 abs, 11 negative-abs (-|x|).
REQ-009 SHALL have port out_valid  output  1: result available.
REQ-010 SHALL have port out_ready  input  1: consumer takes the result.
REQ-011 SHALL have port out_data  output  WIDTH: result.
REQ-012 SHALL have port out_ovf  output  1: result not representable; only meaningful while out_valid=1.
REQ-013 SHALL have port busy  output  1: high in RUN or DONE.

Function
REQ-014 SHALL implement a three-state FSM, IDLE -> RUN -> DONE -> IDLE.
REQ-015 IDLE: in_ready=1; on in_valid=1 SHALL capture in_data into the shift register, capture its MSB into sign_q, and go to RUN.
REQ-016 SHALL decide the invert flag at capture and hold it for the whole operation: pass=0; negate=1; abs=sign; negative-abs=~sign.
REQ-017 SHALL initialise the carry register to the invert flag at capture, and the beat counter to 0.
REQ-018 RUN, each cycle: take the low CHUNK bits of the shift register, XOR them with the invert flag, and add the carry.
REQ-019 RUN, each cycle: shift the register right by CHUNK, insert the CHUNK-bit sum at the top, store the carry-out and increment the counter.
REQ-020 After exactly WIDTH/CHUNK RUN cycles, SHALL go to DONE; the shift register then holds the result.
REQ-021 out_valid SHALL rise on the edge WIDTH/CHUNK cycles after the in_valid&&in_ready edge, i.e. latency N=WIDTH/CHUNK.
REQ-022 DONE: out_valid=1, out_data=shift register, in_ready=0; out_data and out_ovf SHALL be held stable until out_ready=1.
REQ-023 On out_valid&&out_ready in DONE, SHALL return to IDLE; no operand is accepted on that same cycle.
REQ-024 out_ovf SHALL equal invert && sign_q && out_data[WIDTH-1]; this is high only for negate or abs of the most-negative value; out_data is then that value unchanged.
REQ-025 The final carry-out SHALL be discarded, giving modulo-2^WIDTH arithmetic.
REQ-026 in_data and in_mode changes outside the accept cycle SHALL have no effect.
REQ-027 in_ready SHALL be combinationally low whenever state != IDLE; in_valid in RUN/DONE SHALL be ignored.
REQ-028 in_mode=00 SHALL return in_data unchanged with out_ovf=0, still after N cycles.

Reset
REQ-029 With rst=1 at a clock edge, SHALL set state=IDLE, counter=0, carry=0, shift register=0 and sign_q=0.
REQ-030 During and after reset, outputs SHALL be: out_valid=0, out_ovf=0, out_data=0, busy=0, in_ready=1 (from the first cycle after reset).
REQ-031 rst SHALL take priority over all handshakes; a reset in RUN or DONE SHALL abort the operation and produce no result.

Verification
REQ-032 WIDTH=8, CHUNK=1, mode=01, in_data=0x05: out_data=0xFB, out_ovf=0, out_valid exactly 8 cycles after accept.
REQ-033 WIDTH=8, CHUNK=4, mode=01, in_data=0x80: out_data=0x80, out_ovf=1, latency 2; mode=10 with 0x80 gives the same result.
REQ-034 WIDTH=8, CHUNK=2, mode=10, in_data=0xF6: out_data=0x0A, out_ovf=0; mode=11 with 0x0A gives 0xF6; mode=11 with 0x00 gives 0x00.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data is stable, in_ready=0 and extra in_valid pulses are ignored; on release, one result is delivered and in_ready=1 the next cycle.
REQ-036 Reset mid-RUN (cycle 3 of 8): next cycle busy=0, out_valid=0, in_ready=1; a following operand 0x01 mode=01 yields 0xFF.
REQ-037 Randomised: all modes, WIDTH in {8,13,32}, CHUNK dividing WIDTH -> results match the reference-model arithmetic and the out_ovf rule (REQ-024).
